// File: rtl/audio_pkg.sv
// Purpose: shared types for the I2S sample transmit path (sample word, serialiser state).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

    // Bits per audio sample word, sent MSB-first on the wire.
    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Purpose: per-channel left/right sample stream from the audio generator into the I2S transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: each channel's ready is its FIFO not-full; a valid offered while ready=0 is dropped.
// Ports: sample_data_l/r, sample_valid_l/r (source -> sink), left_chan_ready/right_chan_ready (sink -> source).
interface i2s_sample_tx_if;
    import audio_pkg::*;

    sample_t sample_data_l;
    logic    sample_valid_l;
    logic    left_chan_ready;
    sample_t sample_data_r;
    logic    sample_valid_r;
    logic    right_chan_ready;

    modport master (
        output sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
        input  left_chan_ready, right_chan_ready
    );

    modport slave (
        input  sample_data_l, sample_valid_l, sample_data_r, sample_valid_r,
        output left_chan_ready, right_chan_ready
    );
endinterface

// File: rtl/sample_fifo.sv
// Purpose: small synchronous FIFO holding samples for one audio channel.
// Latency: write visible at pop_data the cycle after push; pop_data is the head word, combinational.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep count unchanged.
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data, full, empty.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset: stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_sample_tx.sv
// Purpose: buffers left/right samples and serialises them as I2S (BCLK, DACLRCK, DACDAT) for the codec DAC.
// Latency: first BCLK rise CLK_DIV cycles after leaving IDLE; data bits start one BCLK after each LRCK edge.
// Backpressure: per-channel ready = FIFO not full; a frame start with either FIFO empty sends zeros and flags underrun.
// Ports: clk, reset (sync, active-high), enable, sif (sample stream, slave side), AUD_BCLK, AUD_DACLRCK,
//        AUD_DACDAT, underrun (1-cycle pulse), underrun_count (saturating).
module i2s_sample_tx
    import audio_pkg::*;
#(
    parameter int SLOT_BITS  = 32,   // BCLK periods per channel slot, >= SAMPLE_W+1
    parameter int CLK_DIV    = 16,   // clk cycles per BCLK half-period, >= 1
    parameter int FIFO_DEPTH = 4     // entries per channel FIFO, power of two
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    i2s_sample_tx_if.slave      sif,
    output logic                AUD_BCLK,
    output logic                AUD_DACLRCK,
    output logic                AUD_DACDAT,
    output logic                underrun,
    output logic [15:0]         underrun_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] RIGHT_BASE = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(SAMPLE_W);

    i2s_state_t       state;
    i2s_state_t       state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic [BIT_W-1:0] slot_pos;
    sample_t          sh_l;
    sample_t          sh_r;
    sample_t          head_l;
    sample_t          head_r;
    logic             full_l, full_r;
    logic             empty_l, empty_r;
    logic             both_avail;
    logic             bclk_fall;
    logic             frame_wrap;
    logic             start;
    logic             load;
    logic             pop;
    logic             in_data;

    sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo_l (
        .clk       (clk),
        .reset     (reset),
        .push      (sif.sample_valid_l),
        .push_data (sif.sample_data_l),
        .pop       (pop),
        .pop_data  (head_l),
        .full      (full_l),
        .empty     (empty_l)
    );

    sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo_r (
        .clk       (clk),
        .reset     (reset),
        .push      (sif.sample_valid_r),
        .push_data (sif.sample_data_r),
        .pop       (pop),
        .pop_data  (head_r),
        .full      (full_r),
        .empty     (empty_r)
    );

    assign sif.left_chan_ready  = !full_l;
    assign sif.right_chan_ready = !full_r;

    always_comb begin
        state_nxt  = state;
        both_avail = !empty_l && !empty_r;
        bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        slot_pos   = (bit_nxt >= RIGHT_BASE) ? bit_nxt - RIGHT_BASE : bit_nxt;
        in_data    = (slot_pos != '0) && (slot_pos <= DATA_LAST);
        bclk_fall  = (state != IDLE) && (div_cnt == DIV_LAST) && AUD_BCLK;
        frame_wrap = bclk_fall && (bit_nxt == '0);

        case (state)
            IDLE:    if (enable && both_avail) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)          state_nxt = RUN;
                else if (frame_wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        start = (state == IDLE) && (state_nxt == RUN);
        // A draining serialiser that is still disabled at the wrap stops instead of fetching a new frame.
        load  = frame_wrap && ((state == RUN) || enable);
        // L and R always leave their FIFOs together so the channels stay paired.
        pop   = start || (load && both_avail);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt        <= '0;
            bit_cnt        <= '0;
            AUD_BCLK       <= 1'b0;
            AUD_DACLRCK    <= 1'b0;
            AUD_DACDAT     <= 1'b0;
            sh_l           <= '0;
            sh_r           <= '0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= 1'b0;
            if (start) begin
                div_cnt     <= '0;
                bit_cnt     <= '0;
                AUD_BCLK    <= 1'b0;
                AUD_DACLRCK <= 1'b0;
                AUD_DACDAT  <= 1'b0;
                sh_l        <= head_l;
                sh_r        <= head_r;
            end else if (state == IDLE) begin
                div_cnt     <= '0;
                bit_cnt     <= '0;
                AUD_BCLK    <= 1'b0;
                AUD_DACLRCK <= 1'b0;
                AUD_DACDAT  <= 1'b0;
            end else if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt  <= '0;
                AUD_BCLK <= !AUD_BCLK;
                // Everything the DAC sees moves on the BCLK falling edge so it is stable at the rise.
                if (bclk_fall) begin
                    bit_cnt     <= bit_nxt;
                    AUD_DACLRCK <= (bit_nxt >= RIGHT_BASE);
                    AUD_DACDAT  <= 1'b0;
                    if (load) begin
                        if (both_avail) begin
                            sh_l <= head_l;
                            sh_r <= head_r;
                        end else begin
                            sh_l     <= '0;
                            sh_r     <= '0;
                            underrun <= 1'b1;
                            if (underrun_count != 16'hFFFF) begin
                                underrun_count <= underrun_count + 16'd1;
                            end
                        end
                    end else if (in_data) begin
                        if (bit_nxt < RIGHT_BASE) begin
                            AUD_DACDAT <= sh_l[SAMPLE_W-1];
                            sh_l       <= sh_l << 1;
                        end else begin
                            AUD_DACDAT <= sh_r[SAMPLE_W-1];
                            sh_r       <= sh_r << 1;
                        end
                    end
                end
            end
        end
    end

endmodule
